// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the fetch->execute instruction handshake.
// Handshake: a head entry transfers on every cycle where instr_valid && instr_ready; while instr_valid is high and instr_ready low, Instruction/instr_pc hold.
interface instruction_fetch_unit_if #(
    parameter int PC_W = 8
) ();
    logic            mem_rd_en;
    logic [PC_W-1:0] mem_addr;
    logic [7:0]      mem_rd_data;
    logic [7:0]      Instruction;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rd_data,
        output Instruction, instr_pc, instr_valid,
        input  instr_ready, redirect, redirect_pc,
        output halted
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rd_data,
        input  Instruction, instr_pc, instr_valid,
        output instr_ready, redirect, redirect_pc,
        input  halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads 1-cycle-latency IMEM into a prefetch FIFO, handles redirects.
// Optional macro FETCH_HALT_STOP_EN: stop fetching after an 8'hFF (HALT) byte enters the FIFO.
module instruction_fetch_unit #(
    parameter int IMEM_DEPTH = 20,
    parameter int PC_W       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Enable,
    instruction_fetch_unit_if.master bus,
    output logic [1:0]               dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] resp_pc_q, resp_pc_d;
    logic            inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]      fifo_instr_q [FIFO_DEPTH];
    logic [7:0]      fifo_instr_d [FIFO_DEPTH];
    logic [PC_W-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [PC_W-1:0] fifo_pc_d    [FIFO_DEPTH];

    logic [CNT_W:0]  credit_used;
    logic            credit_ok;
    logic            issue;
    logic            push;
    logic            pop;
    logic            head_valid;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
        head_valid  = (count_q != '0);

        issue = (state_q == ST_FETCH) && Enable && !bus.redirect && credit_ok;
`ifdef FETCH_HALT_STOP_EN
        push  = inflight_q && !bus.redirect && (state_q != ST_HALTED);
`else
        push  = inflight_q && !bus.redirect;
`endif
        pop   = head_valid && bus.instr_ready && !bus.redirect;

        inflight_d = issue;
        if (issue) begin
            resp_pc_d = fetch_pc_q;
            if (fetch_pc_q >= PC_W'(IMEM_DEPTH - 1)) begin
                fetch_pc_d = '0;
            end else begin
                fetch_pc_d = fetch_pc_q + PC_W'(1);
            end
        end

        if (push) begin
            fifo_instr_d[wr_ptr_q] = bus.mem_rd_data;
            fifo_pc_d[wr_ptr_q]    = resp_pc_q;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE:   if (Enable)  state_d = ST_FETCH;
            ST_FETCH:  if (!Enable) state_d = ST_IDLE;
            default:   state_d = state_q;
        endcase

`ifdef FETCH_HALT_STOP_EN
        if (push && (bus.mem_rd_data == 8'hFF)) begin
            state_d = ST_HALTED;
        end
`endif

        // A redirect wins over everything: flush the buffer and drop the in-flight response.
        if (bus.redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            if (bus.redirect_pc >= PC_W'(IMEM_DEPTH)) begin
                fetch_pc_d = '0;
            end else begin
                fetch_pc_d = bus.redirect_pc;
            end
            if (state_q == ST_HALTED) begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= PC_W'(RESET_PC);
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

    assign bus.mem_rd_en   = issue;
    assign bus.mem_addr    = issue ? fetch_pc_q : '0;
    assign bus.instr_valid = head_valid;
    assign bus.Instruction = head_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
`ifdef FETCH_HALT_STOP_EN
    assign bus.halted      = (state_q == ST_HALTED);
`else
    assign bus.halted      = 1'b0;
`endif
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: latency, backpressure, redirect, wrap, reset, HALT.
module tb_instruction_fetch_unit;
    localparam int PC_W       = 8;
    localparam int IMEM_DEPTH = 20;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] dbg_state;
    logic [7:0] imem [256];
    logic       overflow_seen = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         nreq;

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.PC_W(PC_W)) bus ();

    instruction_fetch_unit #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .PC_W(PC_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .RESET_PC(0)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .Enable(en),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // Instruction memory model with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= imem[bus.mem_addr];
    end

    always @(posedge clk) begin
        if (!rst && dut.push && (dut.count_q == 3'(FIFO_DEPTH))) overflow_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Leaves the caller in cycle 0: reset has just been applied, Reset now low.
    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
        chk({tag, "_addr"},  32'(bus.mem_addr), 0);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 0);
        chk({tag, "_instr"}, 32'(bus.Instruction), 0);
        chk({tag, "_pc"},    32'(bus.instr_pc), 0);
        chk({tag, "_halt"},  32'(bus.halted), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'(i + 1);
        rst = 1'b1;
        en = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) cyc();

        // Basic latency and streaming.
        en = 1'b1;
        bus.instr_ready = 1'b1;
        do_reset();
        settle();
        chk_all_zero("t1_reset");
        chk("t1_state_idle", 32'(dbg_state), 0);
        cyc(); settle();
        chk("t1_c1_rd_en", 32'(bus.mem_rd_en), 1);
        chk("t1_c1_addr", 32'(bus.mem_addr), 0);
        cyc(); settle();
        chk("t1_c2_valid", 32'(bus.instr_valid), 0);
        cyc(); settle();
        chk("t1_c3_valid", 32'(bus.instr_valid), 1);
        chk("t1_c3_instr", 32'(bus.Instruction), 32'h01);
        chk("t1_c3_pc", 32'(bus.instr_pc), 0);
        cyc(); settle();
        chk("t1_c4_instr", 32'(bus.Instruction), 32'h02);
        chk("t1_c4_pc", 32'(bus.instr_pc), 1);
        cyc(); settle();
        chk("t1_c5_instr", 32'(bus.Instruction), 32'h03);
        cyc(); settle();
        chk("t1_c6_instr", 32'(bus.Instruction), 32'h04);
        chk("t1_c6_pc", 32'(bus.instr_pc), 3);

        // Backpressure: credit limits outstanding work to FIFO_DEPTH.
        bus.instr_ready = 1'b0;
        do_reset();
        nreq = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc(); settle();
            if (bus.mem_rd_en) begin
                chk("t2_req_addr", 32'(bus.mem_addr), 32'(nreq));
                nreq++;
            end
        end
        chk("t2_nreq", 32'(nreq), 4);
        chk("t2_hold_valid", 32'(bus.instr_valid), 1);
        chk("t2_hold_instr", 32'(bus.Instruction), 32'h01);
        chk("t2_hold_pc", 32'(bus.instr_pc), 0);
        cyc(); bus.instr_ready = 1'b1; settle();
        chk("t2_c11_instr", 32'(bus.Instruction), 32'h01);
        chk("t2_c11_rd_en", 32'(bus.mem_rd_en), 0);
        cyc(); settle();
        chk("t2_c12_instr", 32'(bus.Instruction), 32'h02);
        chk("t2_c12_rd_en", 32'(bus.mem_rd_en), 1);
        chk("t2_c12_addr", 32'(bus.mem_addr), 4);
        cyc(); settle();
        chk("t2_c13_instr", 32'(bus.Instruction), 32'h03);
        cyc(); settle();
        chk("t2_c14_instr", 32'(bus.Instruction), 32'h04);

        // Redirect with 3 buffered entries and one response in flight.
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (4) cyc();
        cyc();
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'd14;
        settle();
        chk("t3_c5_rd_en", 32'(bus.mem_rd_en), 0);
        chk("t3_c5_valid", 32'(bus.instr_valid), 1);
        cyc(); bus.redirect = 1'b0; settle();
        chk("t3_c6_valid", 32'(bus.instr_valid), 0);
        chk("t3_c6_rd_en", 32'(bus.mem_rd_en), 1);
        chk("t3_c6_addr", 32'(bus.mem_addr), 14);
        cyc(); settle();
        chk("t3_c7_valid", 32'(bus.instr_valid), 0);
        cyc(); bus.instr_ready = 1'b1; settle();
        chk("t3_c8_valid", 32'(bus.instr_valid), 1);
        chk("t3_c8_instr", 32'(bus.Instruction), 32'h0F);
        chk("t3_c8_pc", 32'(bus.instr_pc), 14);
        cyc(); settle();
        chk("t3_c9_instr", 32'(bus.Instruction), 32'h10);
        chk("t3_c9_pc", 32'(bus.instr_pc), 15);

        // PC wrap at IMEM_DEPTH.
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'd18;
        cyc(); bus.redirect = 1'b0; settle();
        chk("t4_addr18", 32'(bus.mem_addr), 18);
        cyc(); settle();
        chk("t4_addr19", 32'(bus.mem_addr), 19);
        cyc(); settle();
        chk("t4_addr0", 32'(bus.mem_addr), 0);
        chk("t4_pc18", 32'(bus.instr_pc), 18);
        chk("t4_instr18", 32'(bus.Instruction), 32'h13);
        cyc(); settle();
        chk("t4_addr1", 32'(bus.mem_addr), 1);
        chk("t4_pc19", 32'(bus.instr_pc), 19);
        chk("t4_instr19", 32'(bus.Instruction), 32'h14);
        cyc(); settle();
        chk("t4_pc0", 32'(bus.instr_pc), 0);
        chk("t4_instr0", 32'(bus.Instruction), 32'h01);
        cyc(); settle();
        chk("t4_pc1", 32'(bus.instr_pc), 1);

        // Mid-stream reset, Enable low, IDLE redirect with out-of-range target.
        do_reset();
        settle();
        chk_all_zero("t5_reset");
        cyc(); settle();
        chk("t5_c1_addr", 32'(bus.mem_addr), 0);
        chk("t5_c1_rd_en", 32'(bus.mem_rd_en), 1);
        cyc(); en = 1'b0; settle();
        chk("t5_c2_rd_en", 32'(bus.mem_rd_en), 0);
        chk("t5_c2_valid", 32'(bus.instr_valid), 0);
        cyc(); settle();
        chk("t5_c3_valid", 32'(bus.instr_valid), 1);
        chk("t5_c3_instr", 32'(bus.Instruction), 32'h01);
        chk("t5_c3_pc", 32'(bus.instr_pc), 0);
        cyc();
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'd25;
        settle();
        chk("t5_c4_rd_en", 32'(bus.mem_rd_en), 0);
        cyc(); bus.redirect = 1'b0; en = 1'b1; settle();
        chk("t5_c5_valid", 32'(bus.instr_valid), 0);
        chk("t5_c5_rd_en", 32'(bus.mem_rd_en), 0);
        cyc(); settle();
        chk("t5_c6_rd_en", 32'(bus.mem_rd_en), 1);
        chk("t5_c6_addr", 32'(bus.mem_addr), 0);

        // HALT byte at address 5.
        imem[5] = 8'hFF;
        do_reset();
        repeat (8) cyc();
        settle();
        chk("t6_c8_valid", 32'(bus.instr_valid), 1);
        chk("t6_c8_instr", 32'(bus.Instruction), 32'hFF);
        chk("t6_c8_pc", 32'(bus.instr_pc), 5);
`ifdef FETCH_HALT_STOP_EN
        chk("t6_c8_halted", 32'(bus.halted), 1);
        chk("t6_c8_rd_en", 32'(bus.mem_rd_en), 0);
        cyc(); settle();
        chk("t6_c9_valid", 32'(bus.instr_valid), 0);
        chk("t6_c9_halted", 32'(bus.halted), 1);
        chk("t6_c9_rd_en", 32'(bus.mem_rd_en), 0);
`else
        chk("t6_c8_halted", 32'(bus.halted), 0);
        chk("t6_c8_rd_en", 32'(bus.mem_rd_en), 1);
        chk("t6_c8_addr", 32'(bus.mem_addr), 7);
        cyc(); settle();
        chk("t6_c9_valid", 32'(bus.instr_valid), 1);
        chk("t6_c9_instr", 32'(bus.Instruction), 32'h07);
        chk("t6_c9_pc", 32'(bus.instr_pc), 6);
`endif
        cyc();
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'd0;
        cyc(); bus.redirect = 1'b0; settle();
        chk("t6_c11_halted", 32'(bus.halted), 0);
        chk("t6_c11_rd_en", 32'(bus.mem_rd_en), 1);
        chk("t6_c11_addr", 32'(bus.mem_addr), 0);

        chk("no_overflow", 32'(overflow_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Upstream fetch stage for the 8-bit accumulator processor. It owns the fetch PC, reads the instruction memory (1-cycle read latency) and buffers fetched bytes in a small prefetch FIFO. It presents instructions to the execute stage over a valid/ready handshake, and flushes and refetches when execute reports a branch or return redirect.

Parameters:
IMEM_DEPTH, 20, number of instruction memory words; fetch PC wraps at this bound
PC_W, 8, width of PC and address buses
FIFO_DEPTH, 4, prefetch buffer entries (power of two, >=2)
RESET_PC, 0, fetch PC loaded on reset

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Enable  in  1  fetch enable; low stops new memory requests
mem_rd_en  out  1  instruction memory read strobe
mem_addr  out  PC_W  instruction memory read address
mem_rd_data  in  8  read data, valid the cycle after mem_rd_en
Instruction  out  8  instruction at FIFO head
instr_pc  out  PC_W  PC of the head instruction
instr_valid  out  1  head entry valid
instr_ready  in  1  execute accepts the head this cycle
redirect  in  1  execute requests a PC change (branch taken / return)
redirect_pc  in  PC_W  target PC for redirect
halted  out  1  fetch stopped on HALT (feature only)

Behaviour:
- Reset (checked at the clock edge):
  - outputs mem_rd_en, mem_addr, Instruction, instr_pc, instr_valid and halted are all 0.
  - fetch PC = RESET_PC; FIFO empty; in-flight flag cleared; state IDLE.
  - Reset mid-operation discards all buffered and in-flight data.
- States:
  - IDLE: no requests. Goes to FETCH when Enable=1.
  - FETCH: issue requests. Goes to IDLE when Enable=0.
  - HALTED: feature only; see below.
- Request issue: mem_rd_en=1 and mem_addr=fetch PC when state=FETCH, Enable=1, no redirect this cycle, and registered (occupancy + in-flight) < FIFO_DEPTH.
  - A same-cycle pop does not free credit until the next cycle.
  - On issue, fetch PC increments; IMEM_DEPTH-1 wraps to 0.
- Latency:
  - request in cycle N; mem_rd_data captured with its PC at the end of cycle N+1; instr_valid high in cycle N+2 if the FIFO was empty.
  - Back-to-back requests sustain 1 instruction/cycle once the pipeline is primed.
- Handshake:
  - instr_valid = FIFO non-empty.
  - Pop when instr_valid && instr_ready.
  - Instruction and instr_pc stay stable while instr_valid=1 and instr_ready=0.
  - instr_ready while instr_valid=0 is ignored.
- Full / empty:
  - The credit rule guarantees no overflow.
  - A push into a full FIFO is a design error; the bench asserts it never occurs.
  - Simultaneous push and pop leaves occupancy unchanged.
- Redirect (highest priority):
  - Same cycle: FIFO is flushed; any pop or push is ignored; the response to an outstanding request is marked killed and dropped when it arrives; fetch PC = redirect_pc.
  - redirect_pc >= IMEM_DEPTH loads 0.
  - The first request to the new PC issues the next cycle, if Enable=1.
  - instr_valid=0 in the cycle after a redirect.
  - Redirect in IDLE updates the PC only.
- Enable low: no new requests. An already-issued response is still captured, and the output handshake continues.

Optional Feature:
FETCH_HALT_STOP_EN
- Defined:
  - When the byte being written into the FIFO equals 8'hFF (HALT), no further requests issue, the state goes to HALTED and halted=1 from the next cycle.
  - Entries already in the FIFO, including the HALT, still drain normally.
  - A response already in flight is dropped.
  - Only Reset or redirect leaves HALTED; redirect clears halted and resumes in FETCH.
- Not defined: 8'hFF is fetched like any other byte; halted is tied to 0; fetching continues and wraps.

Test Plan:
- Reset, Enable=1, memory[0..3]=01,02,03,04, instr_ready=1 -> mem_rd_en first in cycle 1 with addr 0; instr_valid rises in cycle 3 with Instruction=01, instr_pc=0; then 02, 03, 04 on consecutive cycles.
- Hold instr_ready=0 for 10 cycles -> exactly 4 requests (addr 0..3); Instruction stays 01; no further mem_rd_en; on release, 01..04 drain one per cycle and fetching resumes at addr 4.
- Redirect to 14 while the FIFO holds 3 entries and a request is in flight -> next-cycle instr_valid=0; stale response dropped; next delivered instr_pc=14 with Instruction=memory[14].
- Fetch past addr 19 with IMEM_DEPTH=20 -> addr sequence 18, 19, 0, 1; instr_pc follows the same sequence.
- Assert Reset in the middle of a stream -> all outputs 0 next cycle; the restart fetches addr 0 with no stale data delivered.
- With FETCH_HALT_STOP_EN: memory[5]=FF -> no request beyond addr 5 or 6; halted=1; FF delivered with instr_pc=5; redirect to 0 clears halted and refetches addr 0.
